// File: rtl/dpram_pkg.sv
// dpram_pkg: shared helpers for the dual-port RAM bank (byte merge, strobe width, latency check)
package dpram_pkg;
   function automatic int strb_w(input int data_w);
      return data_w / 8;
   endfunction
   function automatic bit rd_lat_ok(input int lat);
      return lat == 1 || lat == 2;
   endfunction
   function automatic logic [7:0] byte_merge(input logic [7:0] old_b, input logic [7:0] new_b, input logic strb);
      return strb ? new_b : old_b;
   endfunction
endpackage

// File: rtl/dpram_rd_pipe.sv
// dpram_rd_pipe: per-port read data/valid pipeline of depth LAT with async reset
//   clk, rst   : clock, async active-high reset (clears every stage)
//   req        : read launched this edge
//   din        : array word for the launched read
//   dout/valid : read data (held between reads) and one-cycle completion flag
module dpram_rd_pipe #(
   parameter int W = 8,
   parameter int LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         valid
);
   for (genvar i = 0; i < LAT; i++) begin : g_st
      logic         v;
      logic [W-1:0] d;
      logic         iv;
      logic [W-1:0] id;
      if (i == 0) begin : g_first
         assign iv = req;
         assign id = din;
      end else begin : g_next
         assign iv = g_st[i-1].v;
         assign id = g_st[i-1].d;
      end
      // data loads only with a valid token, so the last stage holds between reads
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            v <= 1'b0;
            d <= '0;
         end else begin
            v <= iv;
            if (iv) d <= id;
         end
   end
   assign dout  = g_st[LAT-1].d;
   assign valid = g_st[LAT-1].v;
endmodule

// File: rtl/dual_port_ram_bank.sv
// dual_port_ram_bank: true dual-port byte-strobed RAM with RD_LAT read pipeline and collision flag
//   clk, rst              : clock, async active-high reset (array contents are kept)
//   ena/enb, wea/web      : port enable, write select (1 = write, 0 = read)
//   addra/addrb           : word address
//   dina/dinb, wstrba/b   : write data and byte strobes
//   douta/doutb, valida/b : read data and read-complete flag
//   collision             : same-address access with at least one write in the previous cycle
module dual_port_ram_bank
   import dpram_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int RD_LAT = 1,
   parameter int INIT_PATTERN = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic                enb,
   input  logic                wea,
   input  logic                web,
   input  logic [ADDR_W-1:0]   addra,
   input  logic [ADDR_W-1:0]   addrb,
   input  logic [DATA_W-1:0]   dina,
   input  logic [DATA_W-1:0]   dinb,
   input  logic [DATA_W/8-1:0] wstrba,
   input  logic [DATA_W/8-1:0] wstrbb,
   output logic [DATA_W-1:0]   douta,
   output logic [DATA_W-1:0]   doutb,
   output logic                valida,
   output logic                validb,
   output logic                collision
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int STRB_W = strb_w(DATA_W);
   if (DATA_W % 8 != 0 || !rd_lat_ok(RD_LAT)) begin : g_bad_param
      $error("dual_port_ram_bank: DATA_W must be a multiple of 8 and RD_LAT must be 1 or 2");
   end
   typedef logic [DATA_W-1:0] mem_t [DEPTH];
   function automatic mem_t init_mem();
      mem_t m;
      for (int i = 0; i < DEPTH; i++) m[i] = INIT_PATTERN != 0 ? DATA_W'(i) : '0;
      return m;
   endfunction
   mem_t mem = init_mem();
   logic              wr_a, wr_b, same_wr;
   logic [DATA_W-1:0] wd_a, wd_b;
   assign wr_a    = ena & wea;
   assign wr_b    = enb & web;
   assign same_wr = wr_a & wr_b & (addra == addrb);
   // on a same-address double write, A merges on top of B's merged word so A wins overlapping bytes
   always_comb begin
      wd_a = '0;
      wd_b = '0;
      for (int k = 0; k < STRB_W; k++) begin
         wd_b[k*8+:8] = byte_merge(mem[addrb][k*8+:8], dinb[k*8+:8], wstrbb[k]);
         wd_a[k*8+:8] = byte_merge(same_wr ? wd_b[k*8+:8] : mem[addra][k*8+:8], dina[k*8+:8], wstrba[k]);
      end
   end
   // A is assigned last so its combined word is the one that lands on an address clash
   always_ff @(posedge clk) begin
      if (wr_b) mem[addrb] <= wd_b;
      if (wr_a) mem[addra] <= wd_a;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) collision <= 1'b0;
      else collision <= ena & enb & (addra == addrb) & (wea | web);
   dpram_rd_pipe #(.W(DATA_W), .LAT(RD_LAT)) u_pipe_a (
      .clk(clk), .rst(rst), .req(ena & ~wea), .din(mem[addra]), .dout(douta), .valid(valida)
   );
   dpram_rd_pipe #(.W(DATA_W), .LAT(RD_LAT)) u_pipe_b (
      .clk(clk), .rst(rst), .req(enb & ~web), .din(mem[addrb]), .dout(doutb), .valid(validb)
   );
endmodule

// File: tb/tb_dual_port_ram_bank.sv
// tb_dual_port_ram_bank: scoreboard bench for two RAM bank configurations (8b/lat1, 32b/lat2)
module tb_dual_port_ram_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int checks = 0;
   int failures = 0;
   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;
   exp_t q1a[$], q1b[$], q2a[$], q2b[$];

   logic       ena1 = 0, enb1 = 0, wea1 = 0, web1 = 0;
   logic [2:0] addra1 = 0, addrb1 = 0;
   logic [7:0] dina1 = 0, dinb1 = 0, douta1, doutb1;
   logic       wstrba1 = 0, wstrbb1 = 0;
   logic       va1, vb1, col1;

   logic        ena2 = 0, enb2 = 0, wea2 = 0, web2 = 0;
   logic [2:0]  addra2 = 0, addrb2 = 0;
   logic [31:0] dina2 = 0, dinb2 = 0, douta2, doutb2;
   logic [3:0]  wstrba2 = 0, wstrbb2 = 0;
   logic        va2, vb2, col2;

   dual_port_ram_bank #(.DATA_W(8), .ADDR_W(3), .RD_LAT(1), .INIT_PATTERN(1)) u1 (
      .clk(clk), .rst(rst), .ena(ena1), .enb(enb1), .wea(wea1), .web(web1),
      .addra(addra1), .addrb(addrb1), .dina(dina1), .dinb(dinb1),
      .wstrba(wstrba1), .wstrbb(wstrbb1), .douta(douta1), .doutb(doutb1),
      .valida(va1), .validb(vb1), .collision(col1)
   );
   dual_port_ram_bank #(.DATA_W(32), .ADDR_W(3), .RD_LAT(2), .INIT_PATTERN(1)) u2 (
      .clk(clk), .rst(rst), .ena(ena2), .enb(enb2), .wea(wea2), .web(web2),
      .addra(addra2), .addrb(addrb2), .dina(dina2), .dinb(dinb2),
      .wstrba(wstrba2), .wstrbb(wstrbb2), .douta(douta2), .doutb(doutb2),
      .valida(va2), .validb(vb2), .collision(col2)
   );

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   `define MON(Q, V, D, NM) \
   always @(negedge clk) begin \
      if (V) begin \
         if (Q.size() == 0) cmp({NM, " spurious valid"}, 32'(V), 0); \
         else begin \
            cmp({NM, " data"}, 32'(D), Q[0].d); \
            cmp({NM, " latency"}, cyc, Q[0].due); \
            void'(Q.pop_front()); \
         end \
      end \
      if (Q.size() != 0 && Q[0].due < cyc) begin \
         cmp({NM, " missing valid"}, cyc, Q[0].due); \
         void'(Q.pop_front()); \
      end \
   end

   `MON(q1a, va1, douta1, "u1 A")
   `MON(q1b, vb1, doutb1, "u1 B")
   `MON(q2a, va2, douta2, "u2 A")
   `MON(q2b, vb2, doutb2, "u2 B")

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ena1 = 0; enb1 = 0; wea1 = 0; web1 = 0; wstrba1 = 0; wstrbb1 = 0;
      ena2 = 0; enb2 = 0; wea2 = 0; web2 = 0; wstrba2 = 0; wstrbb2 = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      cmp("reset douta1", douta1, 0);
      cmp("reset doutb1", doutb1, 0);
      cmp("reset valida1", va1, 0);
      cmp("reset validb1", vb1, 0);
      cmp("reset collision1", col1, 0);
      cmp("reset douta2", douta2, 0);
      cmp("reset valida2", va2, 0);
      cmp("reset collision2", col2, 0);
      rst = 0;
      tick();
      // init pattern: A ascends, B descends, one result per cycle
      for (int i = 0; i < 8; i++) begin
         ena1 = 1; addra1 = 3'(i);
         enb1 = 1; addrb1 = 3'(7 - i);
         q1a.push_back('{d: 32'(i), due: cyc + 1});
         q1b.push_back('{d: 32'(7 - i), due: cyc + 1});
         tick();
      end
      idle();
      tick();
      ena1 = 1; addra1 = 2; enb1 = 1; addrb1 = 2;
      q1a.push_back('{d: 32'h02, due: cyc + 1});
      q1b.push_back('{d: 32'h02, due: cyc + 1});
      tick();
      idle();
      cmp("u1 both-read no collision", col1, 0);
      tick();
      // both ports write addr 5, A wins
      ena1 = 1; enb1 = 1; wea1 = 1; web1 = 1; addra1 = 5; addrb1 = 5;
      dina1 = 8'h12; dinb1 = 8'h34; wstrba1 = 1; wstrbb1 = 1;
      tick();
      idle();
      cmp("u1 write-write collision", col1, 1);
      tick();
      cmp("u1 collision cleared", col1, 0);
      ena1 = 1; addra1 = 5;
      q1a.push_back('{d: 32'h12, due: cyc + 1});
      tick();
      idle();
      // A writes addr 3 while B reads it: old data returned
      ena1 = 1; wea1 = 1; addra1 = 3; dina1 = 8'h55; wstrba1 = 1;
      enb1 = 1; addrb1 = 3;
      q1b.push_back('{d: 32'h03, due: cyc + 1});
      tick();
      idle();
      cmp("u1 write-read collision", col1, 1);
      ena1 = 1; addra1 = 3; enb1 = 1; addrb1 = 3;
      q1a.push_back('{d: 32'h55, due: cyc + 1});
      q1b.push_back('{d: 32'h55, due: cyc + 1});
      tick();
      idle();
      tick();
      // RD_LAT=2 streaming on A
      for (int i = 0; i < 8; i++) begin
         ena2 = 1; addra2 = 3'(i);
         q2a.push_back('{d: 32'(i), due: cyc + 2});
         tick();
      end
      idle();
      repeat (3) tick();
      // byte strobes
      ena2 = 1; wea2 = 1; addra2 = 2; dina2 = 32'hAABBCCDD; wstrba2 = 4'hF;
      tick();
      dina2 = 32'h11223344; wstrba2 = 4'h5;
      tick();
      idle();
      enb2 = 1; addrb2 = 2;
      q2b.push_back('{d: 32'hAA22CC44, due: cyc + 2});
      tick();
      idle();
      // partial overlap double write on addr 6
      ena2 = 1; enb2 = 1; wea2 = 1; web2 = 1; addra2 = 6; addrb2 = 6;
      dina2 = 32'h11111111; wstrba2 = 4'h3;
      dinb2 = 32'h22222222; wstrbb2 = 4'h6;
      tick();
      idle();
      cmp("u2 partial write collision", col2, 1);
      ena2 = 1; addra2 = 6;
      q2a.push_back('{d: 32'h00221111, due: cyc + 2});
      tick();
      idle();
      // zero strobe write changes nothing
      ena2 = 1; wea2 = 1; addra2 = 1; dina2 = 32'hFFFFFFFF; wstrba2 = 4'h0;
      tick();
      idle();
      cmp("u2 single-port no collision", col2, 0);
      enb2 = 1; addrb2 = 1;
      q2b.push_back('{d: 32'h00000001, due: cyc + 2});
      tick();
      idle();
      repeat (3) tick();
      // reset while a read is in flight: it must be dropped
      ena2 = 1; addra2 = 4;
      tick();
      idle();
      #1;
      rst = 1;
      #1;
      cmp("u2 reset mid-read dout", douta2, 0);
      cmp("u2 reset mid-read valid", va2, 0);
      cmp("u1 reset douta", douta1, 0);
      tick();
      tick();
      rst = 0;
      repeat (4) tick();
      ena2 = 1; addra2 = 4;
      q2a.push_back('{d: 32'h00000004, due: cyc + 2});
      tick();
      idle();
      repeat (3) tick();
      // hold: dout keeps last read while idle
      ena1 = 1; addra1 = 6;
      q1a.push_back('{d: 32'h06, due: cyc + 1});
      tick();
      idle();
      for (int j = 0; j < 5; j++) begin
         tick();
         cmp("u1 hold dout", douta1, 8'h06);
         cmp("u1 hold valid", va1, 0);
      end
      repeat (4) tick();
      cmp("scoreboard drained", q1a.size() + q1b.size() + q2a.size() + q2b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
